// File: rtl/upsample_2x.sv
// Nearest-neighbour 2x upsampler. Each input pixel is emitted twice horizontally, and each
// input row is replayed once from a one-row line buffer, giving a 2*IMG_SIZE square output.
// Optional feature macro: UPSAMPLE_TLAST_EN adds a registered last_out end-of-frame flag.
module upsample_2x #(
  parameter int unsigned DATA_WIDTH = 4096,
  parameter int unsigned IMG_SIZE   = 13
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  out_ready
`ifdef UPSAMPLE_TLAST_EN
  ,
  output logic                  last_out
`endif
);

  localparam int unsigned CntW = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(IMG_SIZE - 1);

  typedef enum logic {StFill, StReplay} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         col_q, col_d;
  logic [CntW-1:0]         row_q, row_d;
  logic                    dup_q, dup_d;
  logic                    valid_q, valid_d;
  logic [DATA_WIDTH-1:0]   out_q, out_d;
  logic [DATA_WIDTH-1:0]   line_buf_q [IMG_SIZE];

  logic out_xfer;
  logic in_xfer;
  logic col_end;

  assign out_xfer = valid_q && out_ready;
  assign col_end  = (col_q == CntLast);
  assign in_xfer  = valid_in && in_ready;

  // Upstream ready: FILL accepts when the second copy leaves (except at row end, which enters
  // REPLAY); REPLAY only accepts in its final transfer so the next FILL row has no bubble.
  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StFill:   in_ready = !valid_q || (out_ready && dup_q && !col_end);
      StReplay: in_ready = valid_q && out_ready && dup_q && col_end;
      default:  in_ready = 1'b0;
    endcase
  end

  // Next-state for the FILL/REPLAY sequencer, counters and output register.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dup_d   = dup_q;
    valid_d = valid_q;
    out_d   = out_q;
    if (out_xfer) begin
      if (!dup_q) begin
        dup_d = 1'b1;
      end else if (state_q == StFill) begin
        if (col_end) begin
          // Enter REPLAY with the first buffered word already loaded.
          col_d   = '0;
          state_d = StReplay;
          out_d   = line_buf_q[0];
          dup_d   = 1'b0;
        end else begin
          col_d   = col_q + 1'b1;
          valid_d = 1'b0;
        end
      end else begin
        if (col_end) begin
          col_d   = '0;
          state_d = StFill;
          row_d   = (row_q == CntLast) ? '0 : row_q + 1'b1;
          valid_d = 1'b0;
          dup_d   = 1'b0;
        end else begin
          col_d = col_q + 1'b1;
          out_d = line_buf_q[col_q + 1'b1];
          dup_d = 1'b0;
        end
      end
    end
    if (in_xfer) begin
      out_d   = data_in;
      valid_d = 1'b1;
      dup_d   = 1'b0;
    end
  end

  // Control and output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StFill;
      col_q   <= '0;
      row_q   <= '0;
      dup_q   <= 1'b0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dup_q   <= dup_d;
      valid_q <= valid_d;
      out_q   <= out_d;
    end
  end

  // Line buffer is not reset; col_d is the column the accepted pixel belongs to.
  always_ff @(posedge Clk) begin
    if (in_xfer) begin
      line_buf_q[col_d] <= data_in;
    end
  end

  assign data_out  = out_q;
  assign valid_out = valid_q;

`ifdef UPSAMPLE_TLAST_EN
  logic last_q, last_d;

  // Flag is loaded alongside the final REPLAY copy and held until that word transfers.
  always_comb begin
    last_d = last_q;
    if (out_xfer) begin
      last_d = (state_q == StReplay) && !dup_q && col_end && (row_q == CntLast);
    end
  end

  // End-of-frame flag register.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      last_q <= 1'b0;
    end else begin
      last_q <= last_d;
    end
  end

  assign last_out = last_q;
`endif

endmodule

// File: doc/upsample_2x.md
# upsample_2x

Nearest-neighbour 2x upsampler for the YOLOv3-tiny route/upsample path: it is the inverse of the 2x2 stride-2 maxpool layers. It accepts an IMG_SIZE x IMG_SIZE raster-order stream of channel-packed pixel words and emits a 2·IMG_SIZE x 2·IMG_SIZE stream. Each pixel is repeated horizontally, and each row is repeated vertically from a one-row line buffer. Output is 4x the input volume, so both sides use valid/ready handshakes.

## Interface
- DATA_WIDTH, 4096: pixel word width (128 channels x 32-bit, channel 0 in bits [31:0]).
- IMG_SIZE, 13: input width and height in pixels; output is 2·IMG_SIZE square.
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  input pixel.
- valid_in  input  1  data_in valid.
- in_ready  output  1  block accepts data_in this cycle; transfer occurs when valid_in && in_ready.
- data_out  output  DATA_WIDTH  output pixel (registered).
- valid_out  output  1  data_out valid (registered).
- out_ready  input  1  downstream accepts; transfer occurs when valid_out && out_ready.
- last_out  output  1  only with UPSAMPLE_TLAST_EN; see Configuration.

## Operation
- State: line_buf[IMG_SIZE] of DATA_WIDTH, out_reg, valid_out, dup (0 = first copy, 1 = second copy), col counter (0..IMG_SIZE-1), row counter (0..IMG_SIZE-1), FSM {FILL, REPLAY}.
- FILL (even output rows):
  - in_ready = !valid_out || (out_ready && dup==1).
  - On input transfer: out_reg <= data_in; line_buf[col] <= data_in; valid_out <= 1; dup <= 0.
  - On output transfer with dup==0: dup <= 1 and out_reg is held.
  - On output transfer with dup==1: col increments. If no input transfer occurs in the same cycle, valid_out <= 0.
  - When the dup==1 transfer of col==IMG_SIZE-1 completes: col <= 0, go to REPLAY.
- REPLAY (odd output rows):
  - in_ready = 0.
  - out_reg is loaded from line_buf[col], with valid_out=1, on REPLAY entry and after each dup==1 transfer. Entry load occurs in the same cycle as the FILL exit transfer, so there is no bubble.
  - Each word is sent twice (dup 0, then 1).
  - After the dup==1 transfer of col==IMG_SIZE-1: col <= 0 and go to FILL.
    - If row==IMG_SIZE-1, row <= 0 (frame done); otherwise row increments.
    - valid_out <= 0 unless a FILL input transfer occurs in that same cycle. in_ready is evaluated as FILL-side in the transition cycle, so there is no bubble.
- Output order per input row r: A0 A0 A1 A1 … An An, then the same sequence again.
- data_out holds stable while valid_out && !out_ready. valid_out never drops without a transfer.
- Reset (any time, including mid-row or mid-REPLAY):
  - state=FILL, col=0, row=0, dup=0, valid_out=0, out_reg=0, last_out=0, in_ready=1.
  - line_buf contents are don't-care and are not reset.
- valid_in asserted while in_ready=0 is ignored; upstream must hold the data.

## Timing
- Latency: input transfer at cycle t → data_out valid at t+1.
- Throughput, with out_ready held high: 1 output per cycle sustained. Input is accepted 1 per 2 cycles during FILL and 0 during REPLAY (2·IMG_SIZE cycles).
- Full frame: 4·IMG_SIZE² output cycles minimum.
- in_ready is combinational from out_ready, valid_out, dup and state. There is no combinational path from valid_in to any output.

## Configuration
- UPSAMPLE_TLAST_EN defined: adds port last_out, a registered output asserted with the final output word of a frame. That word is the REPLAY dup==1 word at row==IMG_SIZE-1, col==IMG_SIZE-1. It is held while stalled and cleared after that transfer.
- UPSAMPLE_TLAST_EN undefined: the port and its logic are absent; behaviour is otherwise identical.

## Test plan
- Reset check: IMG_SIZE=2, Rst low mid-stream → valid_out=0, in_ready=1, data_out=0. After release, a fresh frame starts at row 0, col 0.
- Basic order: IMG_SIZE=2, out_ready=1, inputs 1,2,3,4 → data_out sequence 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4 in 16 consecutive cycles, with in_ready low during REPLAY.
- Backpressure: out_ready random 50% → same 16-word sequence; data_out stable whenever valid_out && !out_ready; no word lost or duplicated beyond 2x.
- Upstream gaps: valid_in pulsed every 5th cycle → output order unchanged; valid_out drops only between words.
- Back-to-back frames: IMG_SIZE=13, two frames of a counting pattern 0..168, 169..337 → 676 outputs per frame; the second frame's first output is 169. With UPSAMPLE_TLAST_EN, last_out=1 exactly on the 676th and 1352nd transfers.
- Reset mid-REPLAY: assert Rst during row 0 REPLAY at col 1 → on release the next input is treated as row 0, col 0; no stale REPLAY words appear.
